// File: rtl/wb_stage_if.sv
// ============================================================================
//  Module      : wb_stage_if
//  Description : Upstream, data-memory response and register-file write
//                signals of the writeback stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wdata;

    // Stage side: consumes upstream and memory, drives the register file.
    modport slave (
        input  in_valid, in_rd, in_reg_we, in_is_load, in_funct3, in_result,
        input  mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_wa, rf_wdata
    );

    modport master (
        output in_valid, in_rd, in_reg_we, in_is_load, in_funct3, in_result,
        output mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_wa, rf_wdata
    );
endinterface

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
//  Module      : wb_stage
//  Description : RV32I writeback stage: load alignment/extension, register-file
//                write port and retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    wb_stage_if.slave             bus,
    output logic                  retire_o,
    output logic                  load_err_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      instret_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_LOAD_WAIT = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic             accept;
    logic             ld_done;
    logic             ld_err_new;
    logic [31:0]      ld_ext;
    logic [31:0]      byte_shift;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

    // Pending-load context
    logic [4:0]       ld_rd_q;
    logic             ld_reg_we_q;
    logic [2:0]       ld_funct3_q;
    logic [1:0]       ld_off_q;
    logic             ld_err_q;

    // Writeback registers; rf_wa/rf_wdata keep their value outside WRITE
    logic             we_q;
    logic             err_q;
    logic [4:0]       wa_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = (state_q != S_LOAD_WAIT);
        accept       = bus.in_valid && bus.in_ready;
        ld_done      = (state_q == S_LOAD_WAIT) && bus.mem_rvalid;
        retire_o     = (state_q == S_WRITE);
        load_err_o   = (state_q == S_WRITE) && err_q;
        bus.rf_we    = (state_q == S_WRITE) && we_q;
        busy_o       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE, S_WRITE: begin
                if (accept) begin
                    state_d = bus.in_is_load ? S_LOAD_WAIT : S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = S_WRITE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Misalignment and illegal funct3 are judged at accept; the load still waits.
    always_comb begin
        ld_err_new = 1'b0;
        case (bus.in_funct3)
            3'b000, 3'b100: ld_err_new = 1'b0;
            3'b001, 3'b101: ld_err_new = bus.in_result[0];
            3'b010:         ld_err_new = (bus.in_result[1:0] != 2'b00);
            default:        ld_err_new = 1'b1;
        endcase
    end

    always_comb begin
        byte_shift = bus.mem_rdata >> {ld_off_q, 3'b000};
        ld_byte    = byte_shift[7:0];
        ld_half    = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_ext     = 32'd0;
        case (ld_funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = bus.mem_rdata;
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_rd_q     <= 5'd0;
            ld_reg_we_q <= 1'b0;
            ld_funct3_q <= 3'd0;
            ld_off_q    <= 2'd0;
            ld_err_q    <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            wa_q        <= 5'd0;
            wdata_q     <= 32'd0;
        end else if (accept && bus.in_is_load) begin
            ld_rd_q     <= bus.in_rd;
            ld_reg_we_q <= bus.in_reg_we;
            ld_funct3_q <= bus.in_funct3;
            ld_off_q    <= bus.in_result[1:0];
            ld_err_q    <= ld_err_new;
        end else if (accept) begin
            we_q        <= bus.in_reg_we && (bus.in_rd != 5'd0);
            err_q       <= 1'b0;
            wa_q        <= bus.in_rd;
            wdata_q     <= bus.in_result;
        end else if (ld_done) begin
            we_q        <= ld_reg_we_q && (ld_rd_q != 5'd0) && !ld_err_q;
            err_q       <= ld_err_q;
            wa_q        <= ld_rd_q;
            wdata_q     <= ld_err_q ? 32'd0 : ld_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (state_q == S_WRITE) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign bus.rf_wa    = wa_q;
    assign bus.rf_wdata = wdata_q;
    assign instret_o    = instret_q;

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32I core. Accepts completed instructions from the memory stage through a single-entry valid/ready register.
- For loads, waits for the data-memory response, then aligns and sign- or zero-extends the returned word.
- Drives the register-file write port (rf_we/rf_wa/rf_wdata) from registered outputs.
- Counts retired instructions.

Parameters:
- CNT_W, 32: width of the retired-instruction counter instret.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream holds a completed instruction.
- in_ready  output  1  stage can accept this cycle.
- in_rd  input  5  destination register index.
- in_reg_we  input  1  instruction writes rd.
- in_is_load  input  1  instruction is a load.
- in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_result  input  32  ALU result; for loads, the byte address.
- mem_rvalid  input  1  data-memory read response valid (1-cycle pulse).
- mem_rdata  input  32  data-memory read word (word-aligned).
- rf_we  output  1  register-file write enable.
- rf_wa  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- retire  output  1  1-cycle pulse per retired instruction.
- load_err  output  1  1-cycle pulse on misaligned or illegal-funct3 load.
- busy  output  1  high when state != IDLE.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset values: state IDLE; all outputs 0 except in_ready=1; instret=0; captured fields cleared.
- States:
  - IDLE: nothing held.
  - WRITE: result held; outputs asserted this cycle.
  - LOAD_WAIT: load accepted, awaiting mem_rvalid.
- in_ready = (state==IDLE) || (state==WRITE). It is 0 in LOAD_WAIT.
- Accept (in_valid && in_ready):
  - Capture rd, reg_we, funct3, result[1:0], result.
  - Non-load goes to WRITE next cycle.
  - Load goes to LOAD_WAIT.
- ALU latency: accept in cycle N, then rf_we/retire in cycle N+1. Back-to-back accepts sustain one write per cycle (WRITE to WRITE).
- WRITE, no new accept: return to IDLE next cycle.
- LOAD_WAIT:
  - mem_rvalid=0: hold.
  - mem_rvalid=1: the extended value is computed from mem_rdata, registered, and the state goes to WRITE. Load latency is response cycle + 1.
- Outputs in WRITE:
  - rf_we = reg_we && rd!=0 && !err.
  - rf_wa = rd.
  - rf_wdata = held value.
  - retire = 1.
  - load_err = err.
- Outputs in all other states: rf_we=0, retire=0, load_err=0. rf_wa/rf_wdata hold their last value.
- Load extraction, with a = addr[1:0]:
  - LB/LBU: byte mem_rdata[8a+7:8a], sign- or zero-extended to 32.
  - LH/LHU: halfword at a[1]; a[0]=1 is misaligned.
  - LW: a!=0 is misaligned.
  - funct3 011/110/111 is illegal.
- Error handling:
  - Misaligned or illegal loads still wait for mem_rvalid.
  - In WRITE: load_err=1, rf_we=0, retire=1.
- Zero register: rd=0 never asserts rf_we, but the instruction still retires.
- instret increments by 1 on each retire cycle and wraps modulo 2^CNT_W.
- mem_rvalid in IDLE or WRITE is ignored; no state change.
- Reset in any state, including LOAD_WAIT:
  - Next cycle IDLE; the outstanding load is dropped with no write and no retire.
  - A later stray mem_rvalid is ignored.
- Reset has priority over accept and mem_rvalid in the same cycle.

Test Plan:
- ALU op, rd=5, result 0x1234_5678, in_valid 1 cycle: next cycle rf_we=1, rf_wa=5, rf_wdata=0x12345678, retire=1, instret=1.
- 4 back-to-back ALU ops (rd=1..4), in_valid held: in_ready stays 1; rf_we high 4 consecutive cycles; rf_wa 1,2,3,4; instret=4.
- LB, addr 0x...3, mem_rdata 0x80FF_1122, mem_rvalid 2 cycles after accept:
  - in_ready=0 and busy=1 while waiting.
  - rf_wdata=0xFFFF_FF80 one cycle after mem_rvalid.
  - The same access as LBU gives 0x0000_0080.
- LHU, addr offset 2, mem_rdata 0xBEEF_0001: rf_wdata=0x0000_BEEF. LW at offset 1: load_err=1, rf_we=0, retire=1.
- ALU op with rd=0, result 0xFFFF_FFFF: rf_we=0, retire=1, instret increments.
- Load accepted, reset asserted in LOAD_WAIT, mem_rvalid pulses after reset released: no rf_we, no retire, instret=0, state IDLE, in_ready=1.
